uart_rx_ctrl: RTL and testbench

Receive-side controller that sequences the UART receiver and buffers its output. It enables and disables the receiver and detects each completed frame from the receiver's multi-cycle valid window. Captured bytes go into a small FIFO with a valid/ready read port, and the block keeps sticky overflow, break and idle-timeout status for the host logic. It sits between `uart_rx` and any byte consumer, such as a command parser or bus bridge.

---
 rtl/uart_rx_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: enable sequencing, frame detection, byte FIFO, sticky status
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ctrl_enable,
    input  logic                          ctrl_flush,
    input  logic                          clr_status,
    input  logic                          rx_valid,
    input  logic                          rx_break,
    input  logic [7:0]                    rx_data,
    output logic                          rx_recv_en,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [7:0]                    rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          break_seen,
    output logic                          rx_timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);
    localparam logic [15:0]   TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t       state;
    logic         rx_valid_q;
    logic         rx_break_q;
    logic         rx_armed;
    logic [7:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [15:0]  idle_cnt;

    logic frame_event;
    logic event_taken;
    logic break_event;
    logic push_req;
    logic fifo_full;
    logic do_pop;
    logic do_push;
    logic drop;
    logic idle_clear;
    logic idle_inc;
    logic timeout_hit;

    // Frame detection and FIFO handshake decode. A window that was already
    // open when reset released is ignored: rx_armed only rises once rx_valid
    // has been seen low, so only windows that start after that count.
    always_comb begin
        frame_event = rx_armed & rx_valid_q & ~rx_valid;
        event_taken = frame_event & (state == ST_ACTIVE) & ~ctrl_flush;
        break_event = event_taken & rx_break_q;
        push_req    = event_taken & ~rx_break_q;
        fifo_full   = (fifo_count == FULL_COUNT);
        do_pop      = rd_valid & rd_ready & ~ctrl_flush;
        do_push     = push_req & (~fifo_full | do_pop);
        drop        = push_req & fifo_full & ~do_pop;
        idle_clear  = do_push | do_pop | ctrl_flush | (fifo_count == '0);
        idle_inc    = ~idle_clear & (state == ST_ACTIVE) & (idle_cnt != 16'hFFFF);
        timeout_hit = idle_inc & (idle_cnt == (TIMEOUT_VAL - 16'd1));
    end

    assign rd_valid = (fifo_count != '0);
    assign rd_data  = mem[rd_ptr];

    // Control FSM with registered receiver enable; flush overrides enable changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_DISABLED;
            rx_recv_en <= 1'b0;
        end else if (ctrl_flush) begin
            state      <= ST_FLUSH;
            rx_recv_en <= 1'b0;
        end else begin
            case (state)
                ST_DISABLED: begin
                    if (ctrl_enable) begin
                        state      <= ST_ACTIVE;
                        rx_recv_en <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (!ctrl_enable) begin
                        state      <= ST_DISABLED;
                        rx_recv_en <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    state      <= ctrl_enable ? ST_ACTIVE : ST_DISABLED;
                    rx_recv_en <= ctrl_enable;
                end
                default: begin
                    state      <= ST_DISABLED;
                    rx_recv_en <= 1'b0;
                end
            endcase
        end
    end

    // Delayed copies of the receiver strobes for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid_q <= 1'b0;
            rx_break_q <= 1'b0;
            rx_armed   <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            rx_break_q <= rx_break;
            rx_armed   <= rx_armed | ~rx_valid;
        end
    end

    // Byte storage; deliberately not reset, contents only meaningful under rd_valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Pointers and occupancy; flush empties the FIFO and ignores that cycle's push/pop.
    always_ff @(posedge clk) begin
        if (reset || ctrl_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Saturating idle counter, running only while active with bytes waiting.
    always_ff @(posedge clk) begin
        if (reset || idle_clear) begin
            idle_cnt <= '0;
        end else if (idle_inc) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end

    // Sticky status flags; a set in the same cycle as clr_status wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            break_seen <= 1'b0;
            rx_timeout <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_status) begin
                overflow <= 1'b0;
            end

            if (break_event) begin
                break_seen <= 1'b1;
            end else if (clr_status) begin
                break_seen <= 1'b0;
            end

            if (timeout_hit) begin
                rx_timeout <= 1'b1;
            end else if (idle_clear || clr_status) begin
                rx_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ctrl_enable = 1'b0;
    logic       ctrl_flush = 1'b0;
    logic       clr_status = 1'b0;
    logic       rx_valid = 1'b0;
    logic       rx_break = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_recv_en;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       break_seen;
    logic       rx_timeout;

    int passed = 0;
    int total  = 0;

    uart_rx_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .ctrl_enable(ctrl_enable), .ctrl_flush(ctrl_flush),
        .clr_status(clr_status), .rx_valid(rx_valid), .rx_break(rx_break), .rx_data(rx_data),
        .rx_recv_en(rx_recv_en), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .fifo_count(fifo_count), .overflow(overflow), .break_seen(break_seen), .rx_timeout(rx_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Three-cycle valid window; returns one cycle after the falling edge is sampled.
    task automatic send_byte(input logic [7:0] d, input logic brk);
        rx_data  = d;
        rx_break = brk;
        rx_valid = 1'b1;
        repeat (3) tick();
        rx_valid = 1'b0;
        tick();
        rx_break = 1'b0;
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        total++; if (rx_recv_en !== 1'b0) $display("FAIL reset_recv_en got %b want 0", rx_recv_en); else passed++;
        total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", rd_valid); else passed++;
        total++; if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else passed++;
        total++; if (break_seen !== 1'b0) $display("FAIL reset_break got %b want 0", break_seen); else passed++;
        total++; if (rx_timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", rx_timeout); else passed++;
    endtask

    task automatic test_basic();
        ctrl_enable = 1'b1;
        tick();
        total++; if (rx_recv_en !== 1'b1) $display("FAIL basic_recv_en got %b want 1", rx_recv_en); else passed++;
        send_byte(8'h41, 1'b0);
        send_byte(8'h5A, 1'b0);
        total++; if (fifo_count !== 3'd2) $display("FAIL basic_count2 got %0d want 2", fifo_count); else passed++;
        total++; if (rd_data !== 8'h41) $display("FAIL basic_head got %h want 41", rd_data); else passed++;
        pop_one();
        total++; if (rd_data !== 8'h5A) $display("FAIL basic_second got %h want 5a", rd_data); else passed++;
        total++; if (fifo_count !== 3'd1) $display("FAIL basic_count1 got %0d want 1", fifo_count); else passed++;
        pop_one();
        total++; if (rd_valid !== 1'b0) $display("FAIL basic_drained got %b want 0", rd_valid); else passed++;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_bytes [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
        total++; if (fifo_count !== 3'd4) $display("FAIL ovf_count got %0d want 4", fifo_count); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_data !== exp_bytes[i]) $display("FAIL ovf_pop%0d got %h want %h", i, rd_data, exp_bytes[i]); else passed++;
            pop_one();
        end
        total++; if (fifo_count !== 3'd0) $display("FAIL ovf_empty got %0d want 0", fifo_count); else passed++;
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else passed++;
    endtask

    task automatic test_full_concurrent_pop();
        logic [7:0] exp_bytes [4] = '{8'h12, 8'h13, 8'h14, 8'h06};
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b0);
        rx_data  = 8'h06;
        rx_valid = 1'b1;
        repeat (3) tick();
        rx_valid = 1'b0;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        total++; if (fifo_count !== 3'd4) $display("FAIL fullpop_count got %0d want 4", fifo_count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL fullpop_overflow got %b want 0", overflow); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_data !== exp_bytes[i]) $display("FAIL fullpop_pop%0d got %h want %h", i, rd_data, exp_bytes[i]); else passed++;
            pop_one();
        end
        total++; if (rd_valid !== 1'b0) $display("FAIL fullpop_drained got %b want 0", rd_valid); else passed++;
    endtask

    task automatic test_break();
        send_byte(8'h00, 1'b1);
        total++; if (break_seen !== 1'b1) $display("FAIL break_flag got %b want 1", break_seen); else passed++;
        total++; if (fifo_count !== 3'd0) $display("FAIL break_count got %0d want 0", fifo_count); else passed++;
        ctrl_enable = 1'b0;
        tick();
        total++; if (rx_recv_en !== 1'b0) $display("FAIL disabled_recv_en got %b want 0", rx_recv_en); else passed++;
        send_byte(8'hAA, 1'b0);
        total++; if (fifo_count !== 3'd0) $display("FAIL disabled_count got %0d want 0", fifo_count); else passed++;
        total++; if (break_seen !== 1'b1) $display("FAIL break_sticky got %b want 1", break_seen); else passed++;
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        total++; if (break_seen !== 1'b0) $display("FAIL break_clear got %b want 0", break_seen); else passed++;
    endtask

    task automatic test_timeout_flush();
        ctrl_enable = 1'b1;
        tick();
        send_byte(8'h77, 1'b0);
        repeat (9) tick();
        total++; if (rx_timeout !== 1'b0) $display("FAIL timeout_early got %b want 0", rx_timeout); else passed++;
        tick();
        total++; if (rx_timeout !== 1'b1) $display("FAIL timeout_at10 got %b want 1", rx_timeout); else passed++;
        ctrl_flush = 1'b1;
        tick();
        ctrl_flush = 1'b0;
        total++; if (fifo_count !== 3'd0) $display("FAIL flush_count got %0d want 0", fifo_count); else passed++;
        total++; if (rx_timeout !== 1'b0) $display("FAIL flush_timeout got %b want 0", rx_timeout); else passed++;
        total++; if (rd_valid !== 1'b0) $display("FAIL flush_rd_valid got %b want 0", rd_valid); else passed++;
        tick();
        total++; if (rx_recv_en !== 1'b1) $display("FAIL flush_reactivate got %b want 1", rx_recv_en); else passed++;
    endtask

    task automatic test_reset_mid_window();
        send_byte(8'h33, 1'b0);
        total++; if (fifo_count !== 3'd1) $display("FAIL midrst_pre_count got %0d want 1", fifo_count); else passed++;
        rx_data  = 8'h99;
        rx_valid = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        total++; if (rx_recv_en !== 1'b0) $display("FAIL midrst_recv_en got %b want 0", rx_recv_en); else passed++;
        total++; if (fifo_count !== 3'd0) $display("FAIL midrst_count got %0d want 0", fifo_count); else passed++;
        total++; if (rd_valid !== 1'b0) $display("FAIL midrst_rd_valid got %b want 0", rd_valid); else passed++;
        reset = 1'b0;
        repeat (2) tick();
        rx_valid = 1'b0;
        repeat (2) tick();
        total++; if (fifo_count !== 3'd0) $display("FAIL midrst_no_push got %0d want 0", fifo_count); else passed++;
        total++; if (overflow !== 1'b0 || break_seen !== 1'b0 || rx_timeout !== 1'b0)
            $display("FAIL midrst_status got %b%b%b want 000", overflow, break_seen, rx_timeout); else passed++;
        send_byte(8'h5C, 1'b0);
        total++; if (rd_data !== 8'h5C || fifo_count !== 3'd1)
            $display("FAIL midrst_next_frame got %h/%0d want 5c/1", rd_data, fifo_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_concurrent_pop();
        test_break();
        test_timeout_flush();
        test_reset_mid_window();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
